// File: rtl/mul2_loader.sv
// mul2_loader: collects a 64-element stream into four 4x4 matrices for the
// matrix-squaring multiplier, pulses en_mul for one cycle once a well-framed
// frame is complete, then marks the cycle in which squared results are valid.
//
// Handshake: an element transfers on a rising edge when in_valid && in_ready
// are both high (and clr is low); in_ready depends only on state and reset,
// never on in_valid, so the producer may hold in_valid high across stalls.
module mul2_loader #(
    parameter int DW = 26
) (
    input  logic             clk_ld,
    input  logic             rst_ld,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [64*DW-1:0] mat,
    output logic             en_mul,
    output logic             res_valid,
    output logic             err,
    output logic [15:0]      frame_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        RES  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [64*DW-1:0]   mat_q;
    logic               en_mul_q, res_valid_q, err_q, err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               wr_en;
    logic               accept;

    // Ready only while collecting, and held low while reset is applied.
    assign in_ready = (state_q == LOAD) && !rst_ld;
    assign accept   = in_valid && in_ready;

    // Next-state, slot index, framing error and frame counter decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;
        if (clr) begin
            // Flush wins over everything: no write, no error, no count.
            state_d = LOAD;
            idx_d   = 6'd0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        wr_en = 1'b1;
                        if (idx_q == 6'd63 && in_last) begin
                            state_d = FIRE;
                            idx_d   = 6'd0;
                        end else if (in_last || idx_q == 6'd63) begin
                            // Short frame or missing last marker: drop it.
                            err_d = 1'b1;
                            idx_d = 6'd0;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end
                end
                FIRE: state_d = RES;
                RES: begin
                    state_d     = LOAD;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // Control registers; pulse outputs are registered copies of the next state.
    always_ff @(posedge clk_ld or posedge rst_ld) begin
        if (rst_ld) begin
            state_q     <= LOAD;
            idx_q       <= 6'd0;
            en_mul_q    <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            en_mul_q    <= (state_d == FIRE);
            res_valid_q <= (state_d == RES);
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Matrix storage: the accepted element lands bit-exact in slot idx.
    always_ff @(posedge clk_ld or posedge rst_ld) begin
        if (rst_ld) begin
            mat_q <= '0;
        end else begin
            for (int s = 0; s < 64; s++) begin
                if (wr_en && idx_q == 6'(s)) begin
                    mat_q[DW*s +: DW] <= in_data;
                end
            end
        end
    end

    assign mat       = mat_q;
    assign en_mul    = en_mul_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul2_loader.sv
// Bench for mul2_loader: table of frame scenarios, random frames, and
// hand-written clr / reset / counter-wrap sequences against a queue model.
module tb_mul2_loader;

    localparam int DW = 26;

    logic             clk_ld = 1'b0;
    logic             rst_ld;
    logic             clr;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_last;
    logic             in_ready;
    logic [64*DW-1:0] mat;
    logic             en_mul;
    logic             res_valid;
    logic             err;
    logic [15:0]      frame_cnt;
    logic [1:0]       dbg_state;

    mul2_loader #(.DW(DW)) dut (
        .clk_ld   (clk_ld),
        .rst_ld   (rst_ld),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .mat      (mat),
        .en_mul   (en_mul),
        .res_valid(res_valid),
        .err      (err),
        .frame_cnt(frame_cnt),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk_ld = ~clk_ld;

    int checks   = 0;
    int failures = 0;

    // Reference model: frame contents so far, and what mat should hold.
    logic [DW-1:0] exp_mat[64];
    logic [DW-1:0] frame_q[$];
    logic [15:0]   exp_cnt;

    typedef struct {
        int            n;
        int            last_pos;
        int            kind;
        bit            gap;
        int            exp_outc;   // 1 = fire, 2 = framing error
        bit            chk_o11;
        logic [DW-1:0] exp_o11;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        foreach (exp_mat[s]) exp_mat[s] = '0;
        frame_q.delete();
        exp_cnt = 16'd0;
    endtask

    // Outcome of an accept from the framing rules: 0 none, 1 fire, 2 error.
    task automatic model_accept(input logic [DW-1:0] d, input bit last, output int outc);
        frame_q.push_back(d);
        exp_mat[frame_q.size() - 1] = d;
        outc = 0;
        if (last && frame_q.size() == 64) outc = 1;
        else if (last || frame_q.size() == 64) outc = 2;
        if (outc != 0) frame_q.delete();
    endtask

    function automatic logic [DW-1:0] gen_data(input int kind, input int i);
        logic [DW-1:0] v;
        case (kind)
            0:       v = DW'(i << 13);
            1:       v = 26'h3FFE000;
            default: v = DW'($urandom);
        endcase
        return v;
    endfunction

    // Fixed-point o1_11 of the squared first matrix, from the DUT's mat.
    function automatic logic [DW-1:0] o1_11();
        longint acc = 0;
        for (int k = 0; k < 4; k++) begin
            longint a = longint'($signed(mat[DW*k +: DW]));
            longint b = longint'($signed(mat[DW*(4*k) +: DW]));
            acc += (a * b) >>> 13;
        end
        return DW'(acc);
    endfunction

    task automatic check_mat(input string name);
        int bad = 0;
        for (int s = 0; s < 64; s++) begin
            if (mat[DW*s +: DW] !== exp_mat[s]) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    // Driver: one element, optionally preceded by an idle (garbage) cycle.
    task automatic beat(input logic [DW-1:0] d, input bit last, input bit gap, output int outc);
        int n = 0;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            in_last  = 1'b1;
            @(posedge clk_ld); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 8) begin
            @(posedge clk_ld); #1;
            n++;
        end
        if (n >= 8) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk_ld); #1;
        model_accept(d, last, outc);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_beats(input int n, input int last_pos, input int kind, input bit gap,
                              output int outc);
        bit spurious = 1'b0;
        outc = 0;
        for (int i = 0; i < n; i++) begin
            beat(gen_data(kind, i), (i == last_pos), gap, outc);
            if (i < n - 1 && (err !== 1'b0 || en_mul !== 1'b0 || outc != 0)) spurious = 1'b1;
        end
        check("no_early_pulse", 64'(spurious), 64'd0);
    endtask

    // Called #1 after the final accept edge; checks the FIRE/RES or error tail.
    task automatic check_tail(input int outc, input bit hold_valid);
        if (outc == 1) begin
            if (hold_valid) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
            end
            check("fire_en_mul", 64'(en_mul), 64'd1);
            check("fire_res_valid", 64'(res_valid), 64'd0);
            check("fire_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk_ld); #1;
            exp_cnt = exp_cnt + 16'd1;
            check("res_en_mul", 64'(en_mul), 64'd0);
            check("res_res_valid", 64'(res_valid), 64'd1);
            check("res_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk_ld); #1;
            in_valid = 1'b0;
            check("load_res_valid", 64'(res_valid), 64'd0);
            check("load_in_ready", 64'(in_ready), 64'd1);
            check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
        end else begin
            check("err_pulse", 64'(err), 64'd1);
            check("err_no_en_mul", 64'(en_mul), 64'd0);
            check("err_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk_ld); #1;
            check("err_one_cycle", 64'(err), 64'd0);
            check("err_no_fire", 64'(en_mul), 64'd0);
            check("err_frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
        end
        check_mat("mat");
    endtask

    task automatic run_frame(input int n, input int last_pos, input int kind, input bit gap,
                             input int exp_outc);
        int outc;
        send_beats(n, last_pos, kind, gap, outc);
        check("outcome", 64'(outc), 64'(exp_outc));
        check_tail(exp_outc, gap);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int outc;
        int lp;
        int r;
        bit g;

        vecs[0] = '{64, 63, 0, 1'b0, 1, 1'b1, 26'(56 << 13)};
        vecs[1] = '{64, 63, 2, 1'b1, 1, 1'b0, 26'd0};
        vecs[2] = '{21, 20, 2, 1'b0, 2, 1'b0, 26'd0};
        vecs[3] = '{64, 63, 0, 1'b0, 1, 1'b1, 26'(56 << 13)};
        vecs[4] = '{64, -1, 2, 1'b0, 2, 1'b0, 26'd0};
        vecs[5] = '{64, 63, 1, 1'b0, 1, 1'b1, 26'h0008000};
        vecs[6] = '{10, 9, 2, 1'b1, 2, 1'b0, 26'd0};

        // Reset
        rst_ld   = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        model_reset();
        @(posedge clk_ld); @(posedge clk_ld); #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_en_mul", 64'(en_mul), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_mat", 64'(mat !== '0), 64'd0);
        rst_ld = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Table-driven frame scenarios
        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].n, vecs[v].last_pos, vecs[v].kind, vecs[v].gap, vecs[v].exp_outc);
            if (vecs[v].chk_o11) check("o1_11", 64'(o1_11()), 64'(vecs[v].exp_o11));
        end

        // Random frames, outcome taken from the model's framing rules
        for (int f = 0; f < 6; f++) begin
            r = $urandom_range(0, 3);
            g = 1'($urandom_range(0, 1));
            if (r <= 1)      lp = 63;
            else if (r == 2) lp = $urandom_range(0, 62);
            else             lp = -1;
            send_beats((lp < 0) ? 64 : lp + 1, lp, 2, g, outc);
            check("rand_outcome_known", 64'(outc != 0), 64'd1);
            check_tail(outc, g);
        end

        // clr after 30 elements: element in the clr cycle is dropped, no err
        send_beats(30, -1, 2, 1'b0, outc);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        @(posedge clk_ld); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        frame_q.delete();
        check("clr_no_err", 64'(err), 64'd0);
        check("clr_no_en_mul", 64'(en_mul), 64'd0);
        check("clr_in_ready", 64'(in_ready), 64'd1);
        check_mat("clr_mat_kept");
        run_frame(64, 63, 0, 1'b0, 1);

        // clr during FIRE: RES skipped, count unchanged
        send_beats(64, 63, 2, 1'b0, outc);
        check("clrfire_en_mul", 64'(en_mul), 64'd1);
        clr = 1'b1;
        @(posedge clk_ld); #1;
        clr = 1'b0;
        check("clrfire_res_valid", 64'(res_valid), 64'd0);
        check("clrfire_en_mul_off", 64'(en_mul), 64'd0);
        check("clrfire_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk_ld); #1;
        check("clrfire_res_valid2", 64'(res_valid), 64'd0);
        check("clrfire_frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
        check_mat("clrfire_mat");

        // Async reset in the middle of RES
        send_beats(64, 63, 2, 1'b0, outc);
        @(posedge clk_ld); #1;
        check("pre_rst_res_valid", 64'(res_valid), 64'd1);
        #2;
        rst_ld = 1'b1;
        #1;
        model_reset();
        check("arst_res_valid", 64'(res_valid), 64'd0);
        check("arst_en_mul", 64'(en_mul), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("arst_mat", 64'(mat !== '0), 64'd0);
        @(posedge clk_ld); #1;
        rst_ld = 1'b0;
        @(posedge clk_ld); #1;
        check("arst_no_res_pulse", 64'(res_valid), 64'd0);

        // Counter wrap from 0xFFFF
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk_ld); #1;
        release dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        check("wrap_preload", 64'(frame_cnt), 64'hFFFF);
        run_frame(64, 63, 0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul2_loader.md
# mul2_loader

Stream-to-matrix loader that feeds the matrix-squaring multiplier in the one-unit FastICA datapath. It accepts 26-bit fixed-point elements one per cycle over a valid/ready stream and assembles four 4x4 matrices with framing checks. It then presents the matrices in parallel, pulses the multiplier enable for exactly one cycle, and flags the cycle in which the multiplier's squared outputs are valid for capture.

## Interface
- DW, 26, element width; signed fixed point, 13 fractional bits, matching the multiplier datapath.
- clk_ld  in  1  single clock; all logic on rising edge.
- rst_ld  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous frame flush.
- in_valid  in  1  element present on in_data.
- in_data  in  DW  signed element.
- in_last  in  1  marks the final element of a frame.
- in_ready  out  1  loader can accept an element.
- mat  out  64*DW  four packed matrices. Element index e = 16*(m-1) + 4*(r-1) + (c-1) occupies bits [DW*e +: DW] for matrix m, row r, column c. Each maps to multiplier input i<m>_<r><c>.
- en_mul  out  1  multiplier enable, one-cycle pulse.
- res_valid  out  1  multiplier outputs hold squared results this cycle.
- err  out  1  one-cycle framing error pulse.
- frame_cnt  out  16  completed frames, wraps modulo 2^16.

## Operation
- States: LOAD, FIRE, RES.
- LOAD:
  - in_ready=1; the loader accepts an element on a rising edge when in_valid && in_ready.
  - The accepted element is written to slot idx (6-bit, 0..63) of mat, then idx increments.
  - Stream order is matrix 1..4, each row-major.
- Framing, evaluated on every accept:
  - idx==63 && in_last: write the element, idx→0, state→FIRE.
  - idx<63 && in_last: write the element, then err=1 for one cycle, idx→0, stay in LOAD. The frame is dropped; partially written slots keep their new values.
  - idx==63 && !in_last: write the element, then err=1, idx→0, stay in LOAD. No fire occurs.
- FIRE:
  - en_mul=1, in_ready=0, mat held stable; state→RES unconditionally.
- RES:
  - res_valid=1, en_mul=0, in_ready=0, mat held stable.
  - frame_cnt increments on the edge leaving RES; state→LOAD.
- The downstream capture register must sample the multiplier outputs during the RES cycle only. On the next edge the multiplier reverts to pass-through, because en_mul=0.
- clr (synchronous, overrides all transitions in that cycle):
  - state→LOAD, idx→0.
  - No err pulse; mat and frame_cnt are unchanged.
  - An element presented in the clr cycle is not accepted.
  - If clr is asserted in FIRE, the RES cycle is skipped, res_valid never rises, and frame_cnt does not increment.
- No arithmetic is performed in this block. Elements pass bit-exact; no saturation.

## Timing
- Reset values: state=LOAD, idx=0, mat=0, en_mul=0, res_valid=0, err=0, frame_cnt=0. in_ready=0 while rst_ld is high, then 1 in the first cycle after release.
- en_mul, res_valid and err are registered, so they are glitch-free. in_ready is decoded from state.
- Last-element accept at edge E0:
  - FIRE during cycle E0..E1 (en_mul=1).
  - The multiplier samples at E1.
  - RES during E1..E2 (res_valid=1).
  - LOAD from E2; the first element of the next frame is accepted at E3 at the earliest.
- Throughput: 66 cycles per frame minimum with in_valid held high.
- err rises in the cycle after the offending accept. A back-to-back element can be accepted at the very next edge, since in_ready stays 1.
- Reset asserted mid-frame or in FIRE/RES: all state returns to reset values immediately; no en_mul or res_valid pulse is completed.

## Test plan
- **Nominal frame:** reset, then stream 64 elements with value e<<13 (e = 0..63), in_last on e=63.
  - mat slot e = e<<13; en_mul high exactly one cycle after the last accept; res_valid the following cycle.
  - frame_cnt=1; the multiplier result o1_11 = (0·0+1·4+2·8+3·12)<<13.
- **Back-pressure gaps:** drive in_valid with a 1-0-1-0 pattern over a full frame.
  - Only valid beats are stored, in order; the fire occurs after the 64th valid beat.
  - in_ready=0 during FIRE/RES even with in_valid=1, and no element is lost.
- **Framing errors:**
  - in_last on element 20 → err pulse, no en_mul, idx restarts; the next clean 64-element frame fires normally.
  - 64 elements without in_last → err pulse, no en_mul.
- **Signed values:** a frame of all -1.0 (0x3FFE000).
  - mat slots hold 0x3FFE000 bit-exact; the multiplier o1_11 equals 4.0 (0x0008000).
- **clr cases:**
  - clr after 30 elements → idx=0, no err; the next 64 elements fire normally.
  - clr during FIRE → no res_valid pulse, frame_cnt unchanged.
- **Async reset and wrap:**
  - rst_ld pulsed mid-RES → res_valid drops immediately; all outputs at reset values.
  - Preload frame_cnt to 0xFFFF via 65535 frames (or force), run one frame → frame_cnt=0.
